// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator for a word-addressed data memory.
// Sub-word stores are done as a read of the whole word followed by a merged write.
module load_store_unit #(
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W+1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              ready_o,
   output logic              done_o,
   output logic              err_o,
   output logic [31:0]       rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W+1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_err;
   logic [31:0]       r_rdata;
   logic [31:0]       r_merge;

   logic              w_illegal;
   logic              w_misal;
   logic              w_sub_store;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [31:0]       w_merged;

   // Request checks are made on the live inputs so the error can be latched at accept.
   always_comb begin
      if (we_i) w_illegal = !(funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010);
      else      w_illegal = (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111);
      w_misal = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
   end

   assign w_sub_store = r_we && (r_funct3[1:0] != 2'b10);

   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = mem_rdata_i[7:0];
         2'd1:    w_byte = mem_rdata_i[15:8];
         2'd2:    w_byte = mem_rdata_i[23:16];
         default: w_byte = mem_rdata_i[31:24];
      endcase
      w_half = r_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'd0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = mem_rdata_i;
      endcase
   end

   always_comb begin
      w_merged = r_merge;
      if (r_funct3[1:0] == 2'b00) w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      else                        w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Memory strobes are decoded from state so an async reset drops them immediately.
   always_comb begin
      w_next      = r_state;
      ready_o     = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      mem_wdata_o = 32'd0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (req_i) w_next = (w_illegal || w_misal) ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            if (!r_we || w_sub_store) begin
               mem_read_o = 1'b1;
               w_next     = w_sub_store ? S_MERGE : S_RESP;
            end else begin
               mem_write_o = 1'b1;
               mem_wdata_o = r_wdata;
               w_next      = S_RESP;
            end
         end
         S_MERGE: begin
            mem_write_o = 1'b1;
            mem_wdata_o = w_merged;
            w_next      = S_RESP;
         end
         default: begin
            done_o = 1'b1;
            err_o  = r_err;
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_err    <= 1'b0;
         r_rdata  <= 32'd0;
         r_merge  <= 32'd0;
      end else begin
         if (r_state == S_IDLE && req_i) begin
            r_we     <= we_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_err    <= w_illegal || w_misal;
         end
         if (r_state == S_ACCESS && !r_we)      r_rdata <= w_load;
         if (r_state == S_ACCESS && w_sub_store) r_merge <= mem_rdata_i;
      end
   end

   assign rdata_o     = r_rdata;
   assign mem_addr_o  = r_addr[ADDR_W+1:2];
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a behavioural word memory, per-scenario tasks
// and a scoreboard of expected load results / error flags popped at each done pulse.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [2:0]  f3;
   logic [8:0]  addr;
   logic [31:0] wdata;
   logic        ready_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic [6:0]  mem_addr_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic [1:0]  dbg_state_o;

   logic [31:0] mem [0:127];
   logic        pl_en;
   logic [6:0]  pl_addr;
   logic [31:0] pl_data;
   int          rd_cnt;
   int          wr_cnt;
   int          both_cnt;

   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   logic [31:0] last_rd;
   int          errors;
   int          checks;

   load_store_unit #(.ADDR_W(7)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .we_i        (we),
      .funct3_i    (f3),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .ready_o     (ready_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .mem_addr_o  (mem_addr_o),
      .mem_read_o  (mem_read_o),
      .mem_write_o (mem_write_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .dbg_state_o (dbg_state_o)
   );

   // Clock / reset and memory model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata_i = mem[mem_addr_o];

   always @(posedge clk) begin
      if (mem_write_o)  mem[mem_addr_o] <= mem_wdata_o;
      else if (pl_en)   mem[pl_addr] <= pl_data;
      if (mem_read_o)   rd_cnt <= rd_cnt + 1;
      if (mem_write_o)  wr_cnt <= wr_cnt + 1;
      if (mem_read_o && mem_write_o) both_cnt <= both_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic preload(input logic [6:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [2:0] f, input logic [8:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 99;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done_o) begin
            lat = i;
            break;
         end
      end
   endtask

   // Scenarios
   task automatic test_reset();
      logic [31:0] got [9];
      logic [31:0] want [9];
      int          lat;
      logic [31:0] er;
      logic        ee;
      preload(7'd7, 32'hCAFE_0001);
      exp_q.push_back(32'hCAFE_0001); exp_err_q.push_back(1'b0);
      issue(1'b0, 3'b010, 9'h01C, 32'd0);
      wait_done(lat);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (rdata_o !== er || err_o !== ee || lat != 2) begin
         errors++;
         $display("FAIL pre_reset_lw: rdata=%h err=%b lat=%0d, want %h %b 2", rdata_o, err_o, lat, er, ee);
      end
      @(negedge clk);
      req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 9'h020; wdata = 32'd0;
      @(posedge clk);
      #1 req = 1'b0;
      checks++;
      if (mem_read_o !== 1'b1 || mem_addr_o !== 7'd8) begin
         errors++;
         $display("FAIL pre_reset_access: read=%b addr=%0d, want 1 8", mem_read_o, mem_addr_o);
      end
      #1 rst = 1'b1;
      #1;
      got  = '{32'(ready_o), 32'(done_o), 32'(err_o), rdata_o, 32'(mem_read_o),
               32'(mem_write_o), 32'(mem_addr_o), mem_wdata_o, 32'(dbg_state_o)};
      want = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL reset_out%0d: got %h want %h", i, got[i], want[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'd0;
   endtask

   task automatic test_loads();
      logic [2:0]  t_f3 [5]  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010};
      logic [8:0]  t_ad [5]  = '{9'h015, 9'h016, 9'h016, 9'h016, 9'h014};
      logic [31:0] t_ex [5]  = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF,
                                 32'hFFFF_80FF, 32'h80FF_7F01};
      int          lat;
      logic [31:0] er;
      logic        ee;
      preload(7'd5, 32'h80FF_7F01);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(t_ex[i]); exp_err_q.push_back(1'b0);
         issue(1'b0, t_f3[i], t_ad[i], 32'hFFFF_FFFF);
         wait_done(lat);
         er = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (lat != 2) begin
            errors++;
            $display("FAIL load%0d_latency: got %0d want 2", i, lat);
         end
         checks++;
         if (rdata_o !== er || err_o !== ee) begin
            errors++;
            $display("FAIL load%0d_data: rdata=%h err=%b want %h %b", i, rdata_o, err_o, er, ee);
         end
         @(negedge clk);
         checks++;
         if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL load%0d_pulse: done=%b ready=%b want 0 1", i, done_o, ready_o);
         end
         last_rd = er;
      end
   endtask

   task automatic test_stores();
      logic        t_we [3] = '{1'b1, 1'b1, 1'b1};
      logic [2:0]  t_f3 [3] = '{3'b000, 3'b001, 3'b010};
      logic [8:0]  t_ad [3] = '{9'h015, 9'h016, 9'h1FC};
      logic [31:0] t_wd [3] = '{32'hFFFF_FFAB, 32'h5A5A_1234, 32'hDEAD_BEEF};
      logic [6:0]  t_wa [3] = '{7'd5, 7'd5, 7'd127};
      logic [31:0] t_mv [3] = '{32'h80FF_AB01, 32'h1234_AB01, 32'hDEAD_BEEF};
      int          t_lt [3] = '{3, 3, 2};
      int          t_rd [3] = '{1, 1, 0};
      int          lat, rd0, wr0;
      logic [31:0] er;
      logic        ee;
      for (int i = 0; i < 3; i++) begin
         rd0 = rd_cnt; wr0 = wr_cnt;
         exp_q.push_back(last_rd); exp_err_q.push_back(1'b0);
         issue(t_we[i], t_f3[i], t_ad[i], t_wd[i]);
         wait_done(lat);
         er = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (lat != t_lt[i]) begin
            errors++;
            $display("FAIL store%0d_latency: got %0d want %0d", i, lat, t_lt[i]);
         end
         checks++;
         if (rdata_o !== er || err_o !== ee) begin
            errors++;
            $display("FAIL store%0d_resp: rdata=%h err=%b want %h %b", i, rdata_o, err_o, er, ee);
         end
         checks++;
         if (rd_cnt - rd0 != t_rd[i] || wr_cnt - wr0 != 1) begin
            errors++;
            $display("FAIL store%0d_accesses: reads=%0d writes=%0d want %0d 1",
                     i, rd_cnt - rd0, wr_cnt - wr0, t_rd[i]);
         end
         checks++;
         if (mem[t_wa[i]] !== t_mv[i]) begin
            errors++;
            $display("FAIL store%0d_mem: word=%h want %h", i, mem[t_wa[i]], t_mv[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic        t_we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  t_f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
      logic [8:0]  t_ad [4] = '{9'h013, 9'h011, 9'h014, 9'h014};
      int          lat, wr0;
      logic [31:0] er;
      logic        ee;
      preload(7'd4, 32'h4444_4444);
      for (int i = 0; i < 4; i++) begin
         wr0 = wr_cnt;
         exp_q.push_back(last_rd); exp_err_q.push_back(1'b1);
         issue(t_we[i], t_f3[i], t_ad[i], 32'h0BAD_0BAD);
         wait_done(lat);
         er = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (lat != 1 || err_o !== ee) begin
            errors++;
            $display("FAIL err%0d_resp: lat=%0d err=%b want 1 %b", i, lat, err_o, ee);
         end
         checks++;
         if (rdata_o !== er) begin
            errors++;
            $display("FAIL err%0d_rdata: got %h want %h", i, rdata_o, er);
         end
         checks++;
         if (wr_cnt != wr0 || mem[4] !== 32'h4444_4444 || mem[5] !== 32'h1234_AB01) begin
            errors++;
            $display("FAIL err%0d_nowrite: writes=%0d w4=%h w5=%h want 0 44444444 1234ab01",
                     i, wr_cnt - wr0, mem[4], mem[5]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic [31:0] er;
      logic        ee;
      preload(7'd20, 32'h1122_3344);
      exp_q.push_back(last_rd);       exp_err_q.push_back(1'b0);
      exp_q.push_back(32'h11CC_3344); exp_err_q.push_back(1'b0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; f3 = 3'b000; addr = 9'h052; wdata = 32'h0000_00CC;
      @(posedge clk);
      #1 we = 1'b0; f3 = 3'b010; addr = 9'h050; wdata = 32'd0;
      wait_done(lat);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (lat != 3 || rdata_o !== er || err_o !== ee) begin
         errors++;
         $display("FAIL b2b_sb: lat=%0d rdata=%h err=%b want 3 %h %b", lat, rdata_o, err_o, er, ee);
      end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: ready=%b done=%b want 1 0", ready_o, done_o);
      end
      @(posedge clk);
      #1 req = 1'b0;
      wait_done(lat);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (lat != 2 || rdata_o !== er || err_o !== ee) begin
         errors++;
         $display("FAIL b2b_lw: lat=%0d rdata=%h err=%b want 2 %h %b", lat, rdata_o, err_o, er, ee);
      end
      last_rd = er;
   endtask

   task automatic test_reset_merge();
      int          lat;
      logic [31:0] er;
      logic        ee;
      preload(7'd30, 32'h5566_7788);
      issue(1'b1, 3'b000, 9'h079, 32'h0000_0000);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (mem_write_o !== 1'b1) begin
         errors++;
         $display("FAIL merge_reached: write=%b want 1", mem_write_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_write_o !== 1'b0) begin
         errors++;
         $display("FAIL merge_abort_write: write=%b want 0", mem_write_o);
      end
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (mem[30] !== 32'h5566_7788 || both_cnt != 0) begin
         errors++;
         $display("FAIL merge_abort_mem: word=%h both=%0d want 55667788 0", mem[30], both_cnt);
      end
      exp_q.push_back(32'h5566_7788); exp_err_q.push_back(1'b0);
      issue(1'b0, 3'b010, 9'h078, 32'd0);
      wait_done(lat);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (lat != 2 || rdata_o !== er || err_o !== ee) begin
         errors++;
         $display("FAIL merge_recover: lat=%0d rdata=%h err=%b want 2 %h %b", lat, rdata_o, err_o, er, ee);
      end
   endtask

   initial begin
      errors = 0; checks = 0; last_rd = 32'd0;
      rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = 9'd0; wdata = 32'd0;
      pl_en = 1'b0; pl_addr = 7'd0; pl_data = 32'd0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_back_to_back();
      test_reset_merge();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
